// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: sequential PC generation, one-cycle imem
// read latency, 2-entry {instr, pc} skid FIFO, redirect and reset flush.
module imem_fetch_ctrl #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_req,
  input  logic [DATA_WIDTH-1:0] imem_dout,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [31:0]           instr_pc,
  input  logic                  instr_ready
);

  logic [31:0]           fetch_pc_q,    fetch_pc_d;
  logic                  inflight_q,    inflight_d;
  logic [31:0]           inflight_pc_q, inflight_pc_d;
  logic [1:0]            occ_q,         occ_d;
  logic                  rd_ptr_q,      rd_ptr_d;
  logic                  wr_ptr_q,      wr_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_instr_q [2];
  logic [DATA_WIDTH-1:0] fifo_instr_d [2];
  logic [31:0]           fifo_pc_q    [2];
  logic [31:0]           fifo_pc_d    [2];

  logic       pop;
  logic       push;
  logic [2:0] credit;
  logic       unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Outputs, issue credit and next-state for PC, in-flight slot and FIFO.
  always_comb begin
    instr_valid = (occ_q != 2'd0);
    instr       = fifo_instr_q[rd_ptr_q];
    instr_pc    = fifo_pc_q[rd_ptr_q];
    imem_addr   = fetch_pc_q[ADDR_WIDTH+1:2];

    pop    = instr_valid & instr_ready;
    push   = inflight_q & ~redirect_valid;
    credit = {1'b0, occ_q} + {2'b00, inflight_q};
    // occ + inflight - pop < 2, rearranged to avoid an unsigned underflow.
    imem_req = ~rst & ~redirect_valid & (credit < (3'd2 + {2'b00, pop}));

    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    occ_d         = occ_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fifo_instr_d  = fifo_instr_q;
    fifo_pc_d     = fifo_pc_q;

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      occ_d      = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
    end else begin
      if (imem_req) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 32'd4;
      end
      if (push) begin
        fifo_instr_d[wr_ptr_q] = imem_dout;
        fifo_pc_d[wr_ptr_q]    = inflight_pc_q;
        wr_ptr_d               = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // State registers; reset discards FIFO contents and any in-flight fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      occ_q         <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      occ_q         <= occ_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      fifo_instr_q  <= fifo_instr_d;
      fifo_pc_q     <= fifo_pc_d;
    end
  end

  // The issue credit must never let a response arrive into a full FIFO.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && (occ_q == 2'd2) && !pop));

endmodule
